vproc_mem_responder: RTL and testbench
======================================

Name: vproc_mem_responder

Overview:
- Bus-side responder (target) for the VProc virtual processor bus.
- Sits on the far end of the Addr/WE/RD/DataOut/DataIn/WRAck/RDAck/Burst interface as a word-addressed memory model.
- Supports configurable wait states and multi-beat bursts, and is used as the default test-bench memory and peripheral stub.
- Responds to every address; the memory index wraps modulo the depth.

Parameters:
- MEM_AWIDTH, 10, log2 of memory depth in 32-bit words.
- WR_WAIT, 0, wait cycles inserted before the first beat of a write (0..15).
- RD_WAIT, 1, wait cycles inserted before the first beat of a read (0..15).
- BASE_ADDR, 32'h0, address mapped to word index 0.
- BURST_ADDR_INCR, 1, increment applied to the internal beat address per burst beat.

Ports:
- Clk  input  1  clock, all state on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- Addr  input  32  initiator word address, held until first-beat ack.
- WE  input  1  write request.
- RD  input  1  read request.
- WrData  input  32  write data (initiator DataOut).
- RdData  output  32  read data (initiator DataIn).
- WRAck  output  1  write beat acknowledge.
- RDAck  output  1  read beat acknowledge.
- Burst  input  12  burst length sampled on request; 0 or 1 means single beat.
- BurstFirst  input  1  informational only, ignored.
- BurstLast  input  1  informational only, ignored.

Behaviour:
- Interface (already decided): one clock, Clk; reset nReset is asynchronous and active-low.
- Reset values:
  - WRAck=0, RDAck=0, RdData=0.
  - State=IDLE, beat counter=0, wait counter=0.
  - Memory contents are not cleared.
- Index arithmetic:
  - Index = (Addr - BASE_ADDR) truncated to MEM_AWIDTH bits, computed modulo 2^32.
  - The internal beat address wraps the same way.
- State machine has three states: IDLE, WAIT, ACK.
- IDLE:
  - On a rising edge with WE=1 or RD=1, latch the operation (WE has priority if both are high; treated as a write, RDAck is never asserted), the index, and beats = max(Burst,1).
  - Load the wait counter with WR_WAIT or RD_WAIT.
  - If the wait count is 0, go to ACK; otherwise go to WAIT.
- WAIT: decrement the counter each edge; when it reaches 1, go to ACK on the next edge.
- Entering ACK:
  - For a read, RdData <= mem[index] on the same edge that raises RDAck.
  - For a write, raise WRAck.
  - Minimum latency: request sampled at edge N, ack high after edge N, beat completes at edge N+1 (zero-wait case).
- ACK, each rising edge is one completed beat:
  - Write: mem[beat index] <= WrData.
  - Read: no memory update.
  - Decrement the remaining beats.
  - If beats remain:
    - Keep the ack high.
    - Advance the beat index by BURST_ADDR_INCR.
    - For a read, RdData <= mem[next index] on the same edge.
  - On the last beat: drop the ack and return to IDLE.
- Bursts:
  - Wait states apply only to the first beat. Later beats complete on consecutive edges with no gaps.
  - The initiator's Addr is not re-sampled after the first beat; only the internal beat index is used.
- Back-to-back transfers:
  - The edge that completes a transfer never starts a new one.
  - Requests still high in IDLE on the following edge are treated as a new transfer.
- Reset mid-transfer clears acks and state immediately (asynchronous); completed burst beats remain written.
- RdData holds its last value outside read acks.

Optional Feature:
- Macro: VPROC_RESP_RANDWAIT_EN.
- When defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) steps once per edge.
  - On the IDLE-to-request transition, LFSR[1:0] (0..3) is added to the configured wait count, with the same rules applied.
  - Burst beats are unaffected.
- When undefined: wait counts are exactly WR_WAIT/RD_WAIT and no LFSR logic exists.

Test Plan:
- Single write, WR_WAIT=0: Addr=0x10, WrData=0xDEADBEEF, WE=1 at edge 0 -> WRAck high in cycle 0-1, drops after edge 1; mem[0x10]=0xDEADBEEF.
- Single read, RD_WAIT=2, Addr=0x10 -> RDAck rises after edge 2, RdData=0xDEADBEEF at edge 3, RDAck low after edge 3.
- Write burst, Burst=4, Addr=0x3FE, WrData 1,2,3,4 -> WRAck high for 4 consecutive edges; mem[0x3FE]=1, mem[0x3FF]=2, mem[0x000]=3, mem[0x001]=4 (wrap).
- Read burst, Burst=4, Addr=0x3FE -> RDAck high for 4 consecutive edges; RdData sequence 1,2,3,4.
- WE=1 and RD=1 together, Addr=0x20, WrData=0x55 -> WRAck only, RDAck stays 0; mem[0x20]=0x55.
- nReset pulsed low after beat 2 of a 4-beat write -> WRAck=0 immediately, state IDLE, beats 3-4 not written; a subsequent single read returns beat-2 data.

Source files
------------

// File: rtl/vproc_mem_responder.sv
// Word-addressed memory target for the VProc bus with wait states and bursts.
// Optional VPROC_RESP_RANDWAIT_EN adds 0..3 pseudo-random wait cycles per transfer.
module vproc_mem_responder #(
    parameter int          MEM_AWIDTH      = 10,
    parameter int          WR_WAIT         = 0,
    parameter int          RD_WAIT         = 1,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          BURST_ADDR_INCR = 1
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic        RD,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        WRAck,
    output logic        RDAck,
    input  logic [11:0] Burst,
    input  logic        BurstFirst,
    input  logic        BurstLast
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam int DEPTH = 1 << MEM_AWIDTH;

    logic [31:0]           mem [DEPTH];
    state_t                state, state_d;
    logic [4:0]            wait_cnt, wait_d;
    logic [11:0]           beats, beats_d;
    logic [MEM_AWIDTH-1:0] idx, idx_d;
    logic                  op_wr, op_wr_d;
    logic                  ack, ack_d;
    logic                  rd_load;
    logic [MEM_AWIDTH-1:0] rd_idx;
    logic [31:0]           rd_data;
    logic [31:0]           addr_off;
    logic [MEM_AWIDTH-1:0] req_idx;
    logic [MEM_AWIDTH-1:0] next_idx;
    logic [4:0]            rand_add;
    logic [4:0]            wait_load;

    assign addr_off = Addr - BASE_ADDR;
    assign req_idx  = addr_off[MEM_AWIDTH-1:0];
    assign next_idx = idx + MEM_AWIDTH'(BURST_ADDR_INCR);

    wire unused = &{1'b0, BurstFirst, BurstLast, addr_off[31:MEM_AWIDTH]};

`ifdef VPROC_RESP_RANDWAIT_EN
    logic [15:0] lfsr;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign rand_add = {3'b000, lfsr[1:0]};
`else
    assign rand_add = 5'd0;
`endif

    assign wait_load = (WE ? 5'(WR_WAIT) : 5'(RD_WAIT)) + rand_add;

    always_comb begin
        state_d = state;
        wait_d  = wait_cnt;
        beats_d = beats;
        idx_d   = idx;
        op_wr_d = op_wr;
        ack_d   = ack;
        rd_load = 1'b0;
        rd_idx  = idx;
        case (state)
            S_IDLE: begin
                if (WE || RD) begin
                    op_wr_d = WE;
                    idx_d   = req_idx;
                    beats_d = (Burst == 12'd0) ? 12'd1 : Burst;
                    wait_d  = wait_load;
                    if (wait_load == 5'd0) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        rd_load = !WE;
                        rd_idx  = req_idx;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt <= 5'd1) begin
                    state_d = S_ACK;
                    wait_d  = 5'd0;
                    ack_d   = 1'b1;
                    rd_load = !op_wr;
                    rd_idx  = idx;
                end else begin
                    wait_d = wait_cnt - 5'd1;
                end
            end
            S_ACK: begin
                beats_d = beats - 12'd1;
                if (beats > 12'd1) begin
                    idx_d   = next_idx;
                    rd_load = !op_wr;
                    rd_idx  = next_idx;
                end else begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= S_IDLE;
            wait_cnt <= 5'd0;
            beats    <= 12'd0;
            idx      <= '0;
            op_wr    <= 1'b0;
            ack      <= 1'b0;
            rd_data  <= 32'd0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_d;
            beats    <= beats_d;
            idx      <= idx_d;
            op_wr    <= op_wr_d;
            ack      <= ack_d;
            if (rd_load) begin
                rd_data <= mem[rd_idx];
            end
        end
    end

    // Memory contents survive reset; only beats completed in ACK are stored
    always_ff @(posedge Clk) begin
        if (state == S_ACK && op_wr) begin
            mem[idx] <= WrData;
        end
    end

    assign RdData = rd_data;
    assign WRAck  = ack && op_wr;
    assign RDAck  = ack && !op_wr;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Bench for vproc_mem_responder: transaction-level memory/timing model plus
// literal read-back checks; built with VPROC_RESP_RANDWAIT_EN undefined.
module tb_vproc_mem_responder;

    localparam int          DEPTH      = 1024;
    localparam int          TB_WR_WAIT = 0;
    localparam int          TB_RD_WAIT = 2;
    localparam logic [31:0] TB_BASE    = 32'h0;
    localparam int          INCR       = 1;

    logic        Clk;
    logic        nReset;
    logic [31:0] Addr;
    logic        WE;
    logic        RD;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        WRAck;
    logic        RDAck;
    logic [11:0] Burst;
    logic        BurstFirst;
    logic        BurstLast;

    vproc_mem_responder #(
        .MEM_AWIDTH      (10),
        .WR_WAIT         (TB_WR_WAIT),
        .RD_WAIT         (TB_RD_WAIT),
        .BASE_ADDR       (TB_BASE),
        .BURST_ADDR_INCR (INCR)
    ) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .Addr       (Addr),
        .WE         (WE),
        .RD         (RD),
        .WrData     (WrData),
        .RdData     (RdData),
        .WRAck      (WRAck),
        .RDAck      (RDAck),
        .Burst      (Burst),
        .BurstFirst (BurstFirst),
        .BurstLast  (BurstLast)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_mem [DEPTH];
    logic        exp_wrack;
    logic        exp_rdack;
    logic [31:0] exp_rddata;
    logic        check_en;
    logic [31:0] wdata [16];
    logic [31:0] rd_cap [$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (check_en) begin
            check("wrack", {31'd0, WRAck}, {31'd0, exp_wrack});
            check("rdack", {31'd0, RDAck}, {31'd0, exp_rdack});
            check("rddata", RdData, exp_rddata);
            if (RDAck) rd_cap.push_back(RdData);
        end
    end

    task automatic reset_pulse();
        nReset     = 1'b0;
        exp_wrack  = 1'b0;
        exp_rdack  = 1'b0;
        exp_rddata = 32'd0;
        #2;
        check("async_reset_acks", {30'd0, WRAck, RDAck}, 32'd0);
        #4;
        nReset = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns likewise.
    task automatic xfer(input bit wr, input bit both, input logic [31:0] addr,
                        input logic [11:0] burst, input int abort_after, input bit hold);
        int          n;
        int          w;
        int          idx;
        logic [31:0] off;
        n   = (burst == 12'd0) ? 1 : int'(burst);
        w   = wr ? TB_WR_WAIT : TB_RD_WAIT;
        off = addr - TB_BASE;
        Addr   = addr;
        Burst  = burst;
        WE     = wr;
        RD     = !wr || both;
        WrData = wdata[0];
        @(posedge Clk);
        #1;
        if (!hold) begin
            WE = 1'b0;
            RD = 1'b0;
        end
        repeat (w) begin
            @(posedge Clk);
            #1;
        end
        for (int b = 0; b < n; b++) begin
            idx       = int'((off + 32'(b * INCR)) % DEPTH);
            exp_wrack = wr;
            exp_rdack = !wr;
            if (!wr) exp_rddata = model_mem[idx];
            WrData = wdata[b];
            @(posedge Clk);
            if (wr) model_mem[idx] = WrData;
            #1;
            if (abort_after == b + 1) begin
                reset_pulse();
                return;
            end
        end
        exp_wrack = 1'b0;
        exp_rdack = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        WE = 1'b0;
        RD = 1'b0;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset     = 1'b0;
        Addr       = 32'd0;
        WE         = 1'b0;
        RD         = 1'b0;
        WrData     = 32'd0;
        Burst      = 12'd0;
        BurstFirst = 1'b0;
        BurstLast  = 1'b0;
        exp_wrack  = 1'b0;
        exp_rdack  = 1'b0;
        exp_rddata = 32'd0;
        check_en   = 1'b1;
        for (int i = 0; i < 16; i++) wdata[i] = 32'd0;
        #12;
        check("reset_rddata", RdData, 32'd0);
        check("reset_acks", {30'd0, WRAck, RDAck}, 32'd0);
        nReset = 1'b1;
        @(posedge Clk);
        #1;

        // Single write, then single read with two wait states
        wdata[0] = 32'hDEADBEEF;
        xfer(1'b1, 1'b0, 32'h10, 12'd1, 0, 1'b0);
        idle_cycles(1);
        rd_cap.delete();
        xfer(1'b0, 1'b0, 32'h10, 12'd1, 0, 1'b0);
        idle_cycles(1);
        check("rd_single_cnt", rd_cap.size(), 32'd1);
        check("rd_single", rd_cap.size() > 0 ? rd_cap[0] : 32'hX, 32'hDEADBEEF);

        // Wrapping 4-beat burst write and read-back
        for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
        xfer(1'b1, 1'b0, 32'h3FE, 12'd4, 0, 1'b0);
        idle_cycles(2);
        rd_cap.delete();
        xfer(1'b0, 1'b0, 32'h3FE, 12'd4, 0, 1'b0);
        idle_cycles(1);
        check("rd_burst_cnt", rd_cap.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rd_burst_%0d", i), rd_cap.size() > i ? rd_cap[i] : 32'hX, 32'(i + 1));
        rd_cap.delete();
        xfer(1'b0, 1'b0, 32'h400, 12'd0, 0, 1'b0);
        idle_cycles(1);
        check("rd_wrap_0", rd_cap.size() > 0 ? rd_cap[0] : 32'hX, 32'd3);

        // WE and RD together is a write
        wdata[0] = 32'h55;
        xfer(1'b1, 1'b1, 32'h20, 12'd1, 0, 1'b0);
        idle_cycles(1);
        rd_cap.delete();
        xfer(1'b0, 1'b0, 32'h20, 12'd1, 0, 1'b0);
        check("rd_both", rd_cap.size() > 0 ? rd_cap[0] : 32'hX, 32'h55);

        // Back-to-back writes with the request held across completion
        wdata[0] = 32'h1234;
        xfer(1'b1, 1'b0, 32'h30, 12'd1, 0, 1'b1);
        wdata[0] = 32'h5678;
        xfer(1'b1, 1'b0, 32'h31, 12'd0, 0, 1'b0);
        idle_cycles(1);
        rd_cap.delete();
        xfer(1'b0, 1'b0, 32'h30, 12'd2, 0, 1'b0);
        idle_cycles(1);
        check("b2b_0", rd_cap.size() > 0 ? rd_cap[0] : 32'hX, 32'h1234);
        check("b2b_1", rd_cap.size() > 1 ? rd_cap[1] : 32'hX, 32'h5678);

        // Reset after beat 2 of a 4-beat write leaves beats 3-4 untouched
        for (int i = 0; i < 4; i++) wdata[i] = 32'hAAAA0000 + 32'(i);
        xfer(1'b1, 1'b0, 32'h100, 12'd4, 0, 1'b0);
        idle_cycles(1);
        wdata[0] = 32'h11;
        wdata[1] = 32'h22;
        wdata[2] = 32'h33;
        wdata[3] = 32'h44;
        xfer(1'b1, 1'b0, 32'h100, 12'd4, 2, 1'b0);
        idle_cycles(1);
        rd_cap.delete();
        xfer(1'b0, 1'b0, 32'h101, 12'd1, 0, 1'b0);
        idle_cycles(1);
        check("rst_beat2", rd_cap.size() > 0 ? rd_cap[0] : 32'hX, 32'h22);
        rd_cap.delete();
        xfer(1'b0, 1'b0, 32'h100, 12'd4, 0, 1'b0);
        idle_cycles(2);
        check("rst_b0", rd_cap.size() > 0 ? rd_cap[0] : 32'hX, 32'h11);
        check("rst_b2", rd_cap.size() > 2 ? rd_cap[2] : 32'hX, 32'hAAAA0002);
        check("rst_b3", rd_cap.size() > 3 ? rd_cap[3] : 32'hX, 32'hAAAA0003);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
